// File: rtl/iic_arbmod.sv
// iic_arbmod: round-robin arbiter sharing one I2C transfer engine between
// four client sequencers. A winning client's call is forwarded once the
// engine reports idle; its done pulse and read byte are routed back, and a
// watchdog aborts calls the engine never acknowledges.
//
// Handshake: a client holds its call bits until it sees its oDone bit and
// drops them on the following edge; toward the engine oCall is held until
// the matching iDone bit is sampled high (or the watchdog expires), and a
// new call is only issued while iTag reports the engine idle.
module iic_arbmod #(
   parameter int          NCLIENT = 4,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [7:0]  iCall,
   input  logic [31:0] iData,
   output logic [3:0]  oDone,
   output logic [3:0]  oErr,
   output logic [7:0]  oData,
   output logic [1:0]  oCall,
   output logic [7:0]  oIICData,
   input  logic [1:0]  iDone,
   input  logic [7:0]  iIICData,
   input  logic [1:0]  iTag,
   output logic [1:0]  oGrant,
   output logic        oBusy,
   output logic [2:0]  oState
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_TAG = 3'd1,
      CALL     = 3'd2,
      DONE     = 3'd3,
      HOLD     = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        wr_q, wr_d;        // latched operation: 1 = write, 0 = read
   logic [1:0]  call_q, call_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [3:0]  done_q, done_d;
   logic [3:0]  err_q, err_d;
   logic [15:0] wdog_q, wdog_d;

   logic        found;
   logic [1:0]  idx;
   logic        matched;

   // Next-state and output computation for the grant/call/complete cycle
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      wr_d    = wr_q;
      call_d  = call_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      done_d  = done_q;
      err_d   = err_q;
      wdog_d  = wdog_q;
      found   = 1'b0;
      idx     = 2'd0;
      matched = wr_q ? iDone[1] : iDone[0];

      case (state_q)
         IDLE: begin
            // Scan starts one past the last grant, so i = NCLIENT lands on
            // the last winner itself and it is considered last.
            for (int i = 1; i <= NCLIENT; i++) begin
               idx = grant_q + 2'(i);
               if (!found && (iCall[{idx, 1'b0} +: 2] != 2'b00)) begin
                  found   = 1'b1;
                  grant_d = idx;
                  wr_d    = iCall[{idx, 1'b1}];
                  wdata_d = iData[{idx, 3'b000} +: 8];
               end
            end
            if (found) state_d = WAIT_TAG;
         end
         WAIT_TAG: begin
            if (iTag == 2'b00) begin
               call_d  = wr_q ? 2'b10 : 2'b01;
               wdog_d  = 16'd0;
               state_d = CALL;
            end
         end
         CALL: begin
            if (matched) begin
               call_d          = 2'b00;
               if (!wr_q) rdata_d = iIICData;
               done_d          = 4'b0000;
               done_d[grant_q] = 1'b1;
               err_d           = 4'b0000;
               state_d         = DONE;
            end else if (wdog_q == TIMEOUT - 16'd1) begin
               call_d          = 2'b00;
               done_d          = 4'b0000;
               done_d[grant_q] = 1'b1;
               err_d           = 4'b0000;
               err_d[grant_q]  = 1'b1;
               state_d         = DONE;
            end else if (wdog_q != 16'hFFFF) begin
               wdog_d = wdog_q + 16'd1;
            end
         end
         DONE: begin
            done_d  = 4'b0000;
            err_d   = 4'b0000;
            state_d = HOLD;
         end
         HOLD: begin
            // Dead cycle lets the served client drop its call before a rescan
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= IDLE;
         grant_q <= 2'd3;
         wr_q    <= 1'b0;
         call_q  <= 2'b00;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         done_q  <= 4'b0000;
         err_q   <= 4'b0000;
         wdog_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         wr_q    <= wr_d;
         call_q  <= call_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
      end
   end

   assign oDone    = done_q;
   assign oErr     = err_q;
   assign oData    = rdata_q;
   assign oCall    = call_q;
   assign oIICData = wdata_q;
   assign oGrant   = grant_q;
   assign oBusy    = (state_q != IDLE);
   assign oState   = state_q;

endmodule

// File: tb/tb_iic_arbmod.sv
// tb_iic_arbmod: drives four client models and a behavioural engine into
// iic_arbmod; completions are checked against an expected-record queue.
module tb_iic_arbmod;

   localparam logic [15:0] TMO = 16'd16;
   localparam int          W   = 18;   // {done[3:0], err[3:0], data[7:0], grant[1:0]}

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  call_r;
   logic [31:0] data_r;
   logic [3:0]  oDone, oErr;
   logic [7:0]  oData, oIICData;
   logic [1:0]  oCall, oGrant;
   logic        oBusy;
   logic [2:0]  dbg_state;
   logic [1:0]  iDone, iTag;
   logic [7:0]  iIICData;

   int          total = 0;
   int          bad   = 0;
   logic [W-1:0] exp_q[$];
   logic [1:0]  exp_op[4];
   logic [7:0]  exp_wd[4];
   int          ack_dly[4];     // engine ack delay per client, 0 = never ack
   logic [7:0]  eng_rdata;
   logic [7:0]  model_rdata;
   int          hi_cnt;
   int          exp_hi;
   logic [3:0]  prev_done;

   iic_arbmod #(.NCLIENT(4), .TIMEOUT(TMO)) dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .iCall    (call_r),
      .iData    (data_r),
      .oDone    (oDone),
      .oErr     (oErr),
      .oData    (oData),
      .oCall    (oCall),
      .oIICData (oIICData),
      .iDone    (iDone),
      .iIICData (iIICData),
      .iTag     (iTag),
      .oGrant   (oGrant),
      .oBusy    (oBusy),
      .oState   (dbg_state)
   );

   // clock / global time limit
   always #5 CLOCK = ~CLOCK;

   initial begin
      #100000;
      bad++;
      $display("FAIL global_timeout: got=running exp=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_call(input int k, input logic [1:0] op, input logic [7:0] wd);
      call_r[2*k +: 2] = op;
      data_r[8*k +: 8] = wd;
      exp_op[k] = op[1] ? 2'b10 : 2'b01;
      exp_wd[k] = wd;
   endtask

   task automatic push_exp(input int k, input logic err, input logic rd, input logic [7:0] rb);
      logic [3:0] m;
      m = 4'b0001 << k;
      if (rd && !err) model_rdata = rb;
      exp_q.push_back({m, (err ? m : 4'b0000), model_rdata, 2'(k)});
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_call"},  oCall,     2'b00);
      check({tag, "_wdat"},  oIICData,  8'h00);
      check({tag, "_data"},  oData,     8'h00);
      check({tag, "_done"},  oDone,     4'h0);
      check({tag, "_err"},   oErr,      4'h0);
      check({tag, "_busy"},  oBusy,     1'b0);
      check({tag, "_grant"}, oGrant,    2'd3);
      check({tag, "_state"}, dbg_state, 3'd0);
   endtask

   task automatic wait_idle(input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge CLOCK);
         if (exp_q.size() == 0 && !oBusy && call_r == 8'h00) ok = 1'b1;
      end
      if (!ok) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int k, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge CLOCK);
         if (oDone[k]) ok = 1'b1;
      end
      if (!ok) check({tag, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   // engine model, client call drop and scoreboard compare
   always @(negedge CLOCK) begin
      logic [W-1:0] e;
      if (RESET) begin
         hi_cnt = 0;
         iDone  = 2'b00;
      end else if (oCall != 2'b00) begin
         hi_cnt++;
         // non-matching done bit on the first call cycle must be ignored
         iDone = (hi_cnt == 1) ? ~oCall : 2'b00;
         if (hi_cnt == 1) begin
            check("call_op", oCall, exp_op[oGrant]);
            check("call_wdata", oIICData, exp_wd[oGrant]);
            exp_hi = (ack_dly[oGrant] == 0) ? int'(TMO) : ack_dly[oGrant];
         end
         if (ack_dly[oGrant] != 0 && hi_cnt == ack_dly[oGrant]) begin
            iDone    = oCall;
            iIICData = eng_rdata;
         end
      end else begin
         if (hi_cnt != 0) check("call_len", hi_cnt, exp_hi);
         hi_cnt = 0;
         iDone  = 2'b00;
      end

      if (!RESET && oDone != 4'h0) begin
         check("done_width", prev_done, 4'h0);
         if (exp_q.size() == 0) begin
            check("done_unexpected", oDone, 4'h0);
         end else begin
            e = exp_q.pop_front();
            check("done_rec", {oDone, oErr, oData, oGrant}, e);
         end
         for (int k = 0; k < 4; k++) begin
            if (oDone[k]) begin
               if (call_r[2*k+1]) begin
                  call_r[2*k+1] = 1'b0;
                  exp_op[k] = 2'b01;
               end else begin
                  call_r[2*k] = 1'b0;
               end
            end
         end
      end
      prev_done = oDone;
   end

   // stimulus sequence
   initial begin
      int busy_err;
      call_r = 8'h00;  data_r = 32'h0;
      iTag = 2'b00;    iDone = 2'b00;  iIICData = 8'h00;
      eng_rdata = 8'h00;  model_rdata = 8'h00;
      hi_cnt = 0;  exp_hi = 0;  prev_done = 4'h0;
      for (int k = 0; k < 4; k++) begin
         ack_dly[k] = 4; exp_op[k] = 2'b00; exp_wd[k] = 8'h00;
      end

      repeat (3) @(negedge CLOCK);
      check_reset("rst");
      RESET = 1'b0;

      // single write from client 0, 10-cycle engine ack, 2-cycle call latency
      ack_dly[0] = 10;
      @(negedge CLOCK);
      drive_call(0, 2'b10, 8'hAB);
      push_exp(0, 1'b0, 1'b0, 8'h00);
      @(negedge CLOCK);
      check("lat_wait_call", oCall, 2'b00);
      check("lat_busy", oBusy, 1'b1);
      @(negedge CLOCK);
      check("lat_call", oCall, 2'b10);
      check("wr_grant", oGrant, 2'd0);
      wait_idle("single");

      // contention: 1 and 2 together, then 1 re-calls with a read
      ack_dly[1] = 3; ack_dly[2] = 5; eng_rdata = 8'h77;
      @(negedge CLOCK);
      drive_call(1, 2'b10, 8'h11);
      drive_call(2, 2'b10, 8'h22);
      push_exp(1, 1'b0, 1'b0, 8'h00);
      push_exp(2, 1'b0, 1'b0, 8'h00);
      wait_done(1, "cont1");
      @(negedge CLOCK);
      drive_call(1, 2'b01, 8'h11);
      push_exp(1, 1'b0, 1'b1, 8'h77);
      wait_idle("contention");

      // read return from client 3
      ack_dly[3] = 3; eng_rdata = 8'h5A;
      @(negedge CLOCK);
      drive_call(3, 2'b01, 8'h00);
      push_exp(3, 1'b0, 1'b1, 8'h5A);
      wait_idle("read");
      repeat (5) @(negedge CLOCK);
      check("rd_hold", oData, 8'h5A);

      // busy engine: iTag held for 20 cycles after the grant
      ack_dly[0] = 2;
      @(negedge CLOCK);
      iTag = 2'b01;
      drive_call(0, 2'b10, 8'h33);
      push_exp(0, 1'b0, 1'b0, 8'h00);
      busy_err = 0;
      repeat (20) begin
         @(negedge CLOCK);
         if (oCall != 2'b00) busy_err++;
      end
      check("busy_nocall", busy_err, 0);
      check("busy_flag", oBusy, 1'b1);
      check("busy_grant", oGrant, 2'd0);
      iTag = 2'b00;
      check("busy_tag_edge", oCall, 2'b00);
      @(negedge CLOCK);
      check("busy_call", oCall, 2'b10);
      wait_idle("busy");

      // timeout on client 1 read, then client 2 served
      ack_dly[1] = 0; ack_dly[2] = 4; eng_rdata = 8'hEE;
      @(negedge CLOCK);
      drive_call(1, 2'b01, 8'h44);
      drive_call(2, 2'b10, 8'h55);
      push_exp(1, 1'b1, 1'b1, 8'hEE);
      push_exp(2, 1'b0, 1'b0, 8'h00);
      wait_idle("timeout");
      check("tmo_data_kept", oData, 8'h5A);

      // write+read from client 2, reset during the read call
      ack_dly[2] = 3; eng_rdata = 8'hC3;
      @(negedge CLOCK);
      drive_call(2, 2'b11, 8'h9C);
      push_exp(2, 1'b0, 1'b0, 8'h00);
      wait_done(2, "wr_rd");
      ack_dly[2] = 0;
      begin
         logic ok;
         ok = 1'b0;
         for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLOCK);
            if (oCall == 2'b01) ok = 1'b1;
         end
         check("rd_call_seen", ok, 1'b1);
      end
      repeat (3) @(negedge CLOCK);
      check("rd_call_grant", oGrant, 2'd2);
      check("rd_call_held", oCall, 2'b01);
      RESET = 1'b1;
      call_r = 8'h00;
      @(negedge CLOCK);
      check_reset("midrst");
      check("midrst_q", exp_q.size(), 0);
      @(negedge CLOCK);
      RESET = 1'b0;
      model_rdata = 8'h00;

      // after reset the scan starts at client 0
      ack_dly[0] = 2; ack_dly[3] = 2;
      @(negedge CLOCK);
      drive_call(3, 2'b10, 8'h03);
      drive_call(0, 2'b10, 8'h01);
      push_exp(0, 1'b0, 1'b0, 8'h00);
      push_exp(3, 1'b0, 1'b0, 8'h00);
      wait_idle("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
